// File: rtl/ysyx_24090018_pc_gen.sv
// PC generation stage: issues fetch requests to the IFU over a valid/ready
// handshake, picks the next fetch address from trap, jump and sequential
// sources by fixed priority, and buffers one redirect that arrives while a
// request is outstanding.
//
// Handshake: a request is offered while ifu_valid_o=1 and is taken on an edge
// where ifu_ready_i=1. Once offered, ifu_valid_o stays high and pc_o stays
// constant until the request is taken; stall_i only prevents the next request
// from being offered.
module ysyx_24090018_pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int                    INST_BYTES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_flag_i,
  input  logic [ADDR_WIDTH-1:0] trap_addr_i,
  input  logic                  jump_flag_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  stall_i,
  input  logic                  ifu_ready_i,
  output logic                  ifu_valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  redirect_o,
  output logic                  misalign_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic                    redirect_q;
  logic                    misalign_q;
  logic                    pend_vld_q;
  logic                    pend_trap_q;
  logic [ADDR_WIDTH-1:0]   pend_addr_q;

  // Candidate next PC and whether it comes from a redirect source.
  logic [ADDR_WIDTH-1:0]   pc_d;
  logic                    redir_d;
  logic                    misalign_d;

  // Next-address selection: in REQ the pending entry participates,
  // in BOOT/HOLD only the incoming flags can redirect.
  always_comb begin
    pc_d    = pc_q + PC_INC;
    redir_d = 1'b0;
    if (trap_flag_i) begin
      pc_d    = trap_addr_i;
      redir_d = 1'b1;
    end else if ((state_q == ST_REQ) && pend_vld_q && pend_trap_q) begin
      pc_d    = pend_addr_q;
      redir_d = 1'b1;
    end else if (jump_flag_i) begin
      pc_d    = jump_addr_i;
      redir_d = 1'b1;
    end else if ((state_q == ST_REQ) && pend_vld_q) begin
      pc_d    = pend_addr_q;
      redir_d = 1'b1;
    end
    misalign_d = redir_d && (|(pc_d & ALIGN_MASK));
  end

  // Request FSM, PC register, pending redirect buffer and flag pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      redirect_q  <= 1'b0;
      misalign_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_REQ;
          if (redir_d) pc_q <= pc_d;
          redirect_q <= redir_d;
          misalign_q <= misalign_d;
        end
        ST_REQ: begin
          if (ifu_ready_i) begin
            pc_q       <= pc_d;
            redirect_q <= redir_d;
            misalign_q <= misalign_d;
            pend_vld_q <= 1'b0;
            state_q    <= stall_i ? ST_HOLD : ST_REQ;
          end else begin
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            // A trap replaces anything buffered; a jump never displaces a trap.
            if (trap_flag_i) begin
              pend_vld_q  <= 1'b1;
              pend_trap_q <= 1'b1;
              pend_addr_q <= trap_addr_i;
            end else if (jump_flag_i && !(pend_vld_q && pend_trap_q)) begin
              pend_vld_q  <= 1'b1;
              pend_trap_q <= 1'b0;
              pend_addr_q <= jump_addr_i;
            end
          end
        end
        ST_HOLD: begin
          if (redir_d) pc_q <= pc_d;
          redirect_q <= redir_d;
          misalign_q <= misalign_d;
          if (!stall_i) state_q <= ST_REQ;
        end
        default: begin
          state_q    <= ST_BOOT;
          redirect_q <= 1'b0;
          misalign_q <= 1'b0;
        end
      endcase
    end
  end

  assign ifu_valid_o = (state_q == ST_REQ);
  assign pc_o        = pc_q;
  assign redirect_o  = redirect_q;
  assign misalign_o  = misalign_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_24090018_pc_gen.sv
// Bench for ysyx_24090018_pc_gen: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_ysyx_24090018_pc_gen;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        trap_flag_i;
  logic [31:0] trap_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        stall_i;
  logic        ifu_ready_i;
  logic        ifu_valid_o;
  logic [31:0] pc_o;
  logic        redirect_o;
  logic        misalign_o;
  logic [1:0]  dbg_state_o;

  int total;
  int bad;

  ysyx_24090018_pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .trap_flag_i (trap_flag_i),
    .trap_addr_i (trap_addr_i),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .stall_i     (stall_i),
    .ifu_ready_i (ifu_ready_i),
    .ifu_valid_o (ifu_valid_o),
    .pc_o        (pc_o),
    .redirect_o  (redirect_o),
    .misalign_o  (misalign_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic        trap;
    logic [31:0] addr;
  } pend_t;

  pend_t       pend_q[$];   // at most one entry
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_booting;   // first cycle after reset: no request yet
  logic        m_redir;
  logic        m_mis;

  task automatic model_edge(input logic r, input logic t, input logic [31:0] ta,
                            input logic j, input logic [31:0] ja,
                            input logic s, input logic rdy);
    logic        take;
    logic [31:0] tgt;
    logic        has_pt;
    logic        has_pj;
    take = 1'b0;
    tgt  = 32'd0;
    if (r) begin
      m_pc      = RV;
      m_valid   = 1'b0;
      m_booting = 1'b1;
      pend_q.delete();
      m_redir   = 1'b0;
      m_mis     = 1'b0;
      return;
    end
    if (!m_valid) begin
      // no request outstanding: redirect applies straight away
      if (t) begin take = 1'b1; tgt = ta; end
      else if (j) begin take = 1'b1; tgt = ja; end
      m_valid   = m_booting ? 1'b1 : !s;
      m_booting = 1'b0;
      if (take) m_pc = tgt;
      m_redir = take;
      m_mis   = take && ((tgt % 4) != 0);
    end else if (rdy) begin
      has_pt = (pend_q.size() > 0) && pend_q[0].trap;
      has_pj = (pend_q.size() > 0) && !pend_q[0].trap;
      if (t) begin take = 1'b1; tgt = ta; end
      else if (has_pt) begin take = 1'b1; tgt = pend_q[0].addr; end
      else if (j) begin take = 1'b1; tgt = ja; end
      else if (has_pj) begin take = 1'b1; tgt = pend_q[0].addr; end
      m_pc    = take ? tgt : m_pc + 32'd4;
      m_redir = take;
      m_mis   = take && ((tgt % 4) != 0);
      pend_q.delete();
      m_valid = !s;
    end else begin
      m_redir = 1'b0;
      m_mis   = 1'b0;
      if (t) begin
        pend_q.delete();
        pend_q.push_back('{trap: 1'b1, addr: ta});
      end else if (j && !((pend_q.size() > 0) && pend_q[0].trap)) begin
        pend_q.delete();
        pend_q.push_back('{trap: 1'b0, addr: ja});
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, let the edge happen, then compare with the model.
  task automatic step(input logic r, input logic t, input logic [31:0] ta,
                      input logic j, input logic [31:0] ja,
                      input logic s, input logic rdy);
    @(negedge clk);
    rst         = r;
    trap_flag_i = t;
    trap_addr_i = ta;
    jump_flag_i = j;
    jump_addr_i = ja;
    stall_i     = s;
    ifu_ready_i = rdy;
    @(posedge clk);
    model_edge(r, t, ta, j, ja, s, rdy);
    #1;
    check_eq("valid",    {31'd0, ifu_valid_o}, {31'd0, m_valid});
    check_eq("pc",       pc_o,                 m_pc);
    check_eq("redirect", {31'd0, redirect_o},  {31'd0, m_redir});
    check_eq("misalign", {31'd0, misalign_o},  {31'd0, m_mis});
  endtask

  task automatic idle(input logic s, input logic rdy);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, s, rdy);
  endtask

  task automatic jump(input logic [31:0] a, input logic s, input logic rdy);
    step(1'b0, 1'b0, 32'd0, 1'b1, a, s, rdy);
  endtask

  task automatic trap(input logic [31:0] a, input logic s, input logic rdy);
    step(1'b0, 1'b1, a, 1'b0, 32'd0, s, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r, t, j, s, rdy;
    logic [31:0] ta, ja;
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    trap_flag_i = 1'b0;
    trap_addr_i = 32'd0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'd0;
    stall_i     = 1'b0;
    ifu_ready_i = 1'b1;

    // reset and stream
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("boot_pc", pc_o, RV);
    check_eq("boot_valid", {31'd0, ifu_valid_o}, 32'd0);
    idle(1'b0, 1'b1);
    check_eq("first_req", pc_o, RV);
    check_eq("first_valid", {31'd0, ifu_valid_o}, 32'd1);
    idle(1'b0, 1'b1);
    check_eq("seq_4", pc_o, 32'h8000_0004);
    idle(1'b0, 1'b1);
    check_eq("seq_8", pc_o, 32'h8000_0008);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check_eq("seq_10", pc_o, 32'h8000_0010);

    // backpressure with buffered jump
    jump(32'h8000_0100, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check_eq("bp_hold", pc_o, 32'h8000_0010);
    idle(1'b0, 1'b1);
    check_eq("bp_target", pc_o, 32'h8000_0100);
    check_eq("bp_redirect", {31'd0, redirect_o}, 32'd1);

    // priority between pending and incoming redirects
    jump(32'h0000_0200, 1'b0, 1'b0);
    trap(32'h0000_0300, 1'b0, 1'b0);
    jump(32'h0000_0400, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
    check_eq("prio_trap", pc_o, 32'h0000_0300);
    step(1'b0, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600, 1'b0, 1'b1);
    check_eq("same_cycle", pc_o, 32'h0000_0500);
    idle(1'b0, 1'b1);
    check_eq("dropped_jump", pc_o, 32'h0000_0504);

    // stall after handshake, redirect while held
    jump(32'h8000_0020, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    check_eq("stall_pc", pc_o, 32'h8000_0024);
    check_eq("stall_valid", {31'd0, ifu_valid_o}, 32'd0);
    jump(32'h8000_0080, 1'b1, 1'b0);
    check_eq("hold_jump", pc_o, 32'h8000_0080);
    idle(1'b0, 1'b0);
    check_eq("unstall_valid", {31'd0, ifu_valid_o}, 32'd1);
    check_eq("unstall_pc", pc_o, 32'h8000_0080);

    // misaligned target and wrap-around
    jump(32'h8000_0102, 1'b0, 1'b1);
    check_eq("mis_flag", {31'd0, misalign_o}, 32'd1);
    jump(32'hFFFF_FFFC, 1'b0, 1'b1);
    check_eq("mis_clear", {31'd0, misalign_o}, 32'd0);
    idle(1'b0, 1'b1);
    check_eq("wrap", pc_o, 32'h0000_0000);
    check_eq("wrap_noredir", {31'd0, redirect_o}, 32'd0);

    // reset with a pending trap
    trap(32'h0000_0700, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_eq("rst_pc", pc_o, RV);
    check_eq("rst_valid", {31'd0, ifu_valid_o}, 32'd0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check_eq("rst_discard", pc_o, RV + 32'd4);
    check_eq("rst_noredir", {31'd0, redirect_o}, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      t   = ($urandom_range(0, 11) == 0);
      j   = ($urandom_range(0, 5) == 0);
      s   = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      ta  = $urandom;
      ja  = $urandom;
      if ($urandom_range(0, 3) != 0) ta[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) ja[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) ja = 32'hFFFF_FFF0 | (ja & 32'hC);
      step(r, t, ta, j, ja, s, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
